io_port_unit: RTL and testbench

Memory-mapped I/O port block for the single-cycle MIPS CPU. Sits downstream of the control unit. It consumes the IORead/IOWrite strobes that decode as I/O accesses in the 0xFFFFFC00–0xFFFFFFFF window, plus the low address bits and the store data. It holds the board output state (24 LEDs, 8-digit seven-segment display) and synchronises and debounces the board inputs (24 switches, one confirm button). Load data goes back to the memory/IO write-back mux.

---
 rtl/io_port_unit.sv | 158 +++++++++++++++
 tb/tb_io_port_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/io_port_unit.sv
// Memory-mapped I/O port: LEDs, scanned 8-digit seven-segment display,
// synchronised switches and a debounced confirm button with press flag.
module io_port_unit #(
   parameter int unsigned SCAN_DIV        = 20000,
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IORead,
   input  logic        IOWrite,
   input  logic [9:0]  addr_low,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [23:0] switch_in,
   input  logic        button_in,
   output logic [23:0] led,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_data
);

   localparam logic [9:0] OFF_LED     = 10'h060;
   localparam logic [9:0] OFF_SEGDATA = 10'h064;
   localparam logic [9:0] OFF_SEGEN   = 10'h068;
   localparam logic [9:0] OFF_SWITCH  = 10'h070;
   localparam logic [9:0] OFF_BUTTON  = 10'h074;

   localparam int unsigned DIV_W = $clog2(SCAN_DIV);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic [9:0]       offset;
   logic             unused_addr_bits;
   logic [31:0]      segdata;
   logic [7:0]       segen;
   logic [23:0]      switch_meta, switch_sync;
   logic             btn_meta, btn_sync, btn_stable, press_flag;
   logic [DEB_W-1:0] deb_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       digit_idx;
   logic             btn_accept, btn_rise, button_read;
   logic [3:0]       nibble;
   logic [7:0]       hex_seg;

   assign offset           = {addr_low[9:2], 2'b00};
   assign unused_addr_bits = ^addr_low[1:0];

   // Write-side registers
   always_ff @(posedge clock) begin
      if (reset) begin
         led     <= '0;
         segdata <= '0;
         segen   <= '0;
      end else if (IOWrite) begin
         case (offset)
            OFF_LED:     led     <= wdata[23:0];
            OFF_SEGDATA: segdata <= wdata;
            OFF_SEGEN:   segen   <= wdata[7:0];
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         switch_meta <= '0;
         switch_sync <= '0;
         btn_meta    <= 1'b0;
         btn_sync    <= 1'b0;
      end else begin
         switch_meta <= switch_in;
         switch_sync <= switch_meta;
         btn_meta    <= button_in;
         btn_sync    <= btn_meta;
      end
   end

   // Flag is set on the same edge btn_stable rises, and that set beats a read-clear
   assign btn_accept  = (btn_sync != btn_stable) && (deb_cnt == DEB_LAST);
   assign btn_rise    = btn_accept && btn_sync;
   assign button_read = IORead && (offset == OFF_BUTTON);

   always_ff @(posedge clock) begin
      if (reset) begin
         deb_cnt    <= '0;
         btn_stable <= 1'b0;
         press_flag <= 1'b0;
      end else begin
         if (btn_sync == btn_stable) begin
            deb_cnt <= '0;
         end else if (btn_accept) begin
            deb_cnt    <= '0;
            btn_stable <= btn_sync;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
         if (btn_rise)
            press_flag <= 1'b1;
         else if (button_read)
            press_flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (IORead) begin
         case (offset)
            OFF_SWITCH: rdata = {8'h00, switch_sync};
            OFF_BUTTON: rdata = {30'h0, press_flag, btn_stable};
            default:    rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt   <= '0;
         digit_idx <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt   <= '0;
         digit_idx <= digit_idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign nibble = segdata[{digit_idx, 2'b00} +: 4];

   always_comb begin
      hex_seg = 8'hFF;
      case (nibble)
         4'h0: hex_seg = 8'hC0;
         4'h1: hex_seg = 8'hF9;
         4'h2: hex_seg = 8'hA4;
         4'h3: hex_seg = 8'hB0;
         4'h4: hex_seg = 8'h99;
         4'h5: hex_seg = 8'h92;
         4'h6: hex_seg = 8'h82;
         4'h7: hex_seg = 8'hF8;
         4'h8: hex_seg = 8'h80;
         4'h9: hex_seg = 8'h90;
         4'hA: hex_seg = 8'h88;
         4'hB: hex_seg = 8'h83;
         4'hC: hex_seg = 8'hC6;
         4'hD: hex_seg = 8'hA1;
         4'hE: hex_seg = 8'h86;
         4'hF: hex_seg = 8'h8E;
         default: hex_seg = 8'hFF;
      endcase
   end

   always_comb begin
      seg_an            = '1;
      seg_an[digit_idx] = ~segen[digit_idx];
      seg_data          = segen[digit_idx] ? hex_seg : 8'hFF;
   end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit with SCAN_DIV = 4, DEBOUNCE_CYCLES = 8.
module tb_io_port_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        IORead, IOWrite;
   logic [9:0]  addr_low;
   logic [31:0] wdata, rdata;
   logic [23:0] switch_in, led;
   logic        button_in;
   logic [7:0]  seg_an, seg_data;

   int unsigned checks = 0;
   int unsigned fails  = 0;
   int unsigned n      = 0;

   logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct {
      logic        rd;
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rdata;
      logic [23:0] exp_led;
   } vec_t;
   vec_t vecs [8];

   typedef struct {
      logic [31:0] segd;
      logic [7:0]  en;
   } disp_t;
   disp_t disps [3];

   io_port_unit #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
      .addr_low(addr_low), .wdata(wdata), .rdata(rdata),
      .switch_in(switch_in), .button_in(button_in),
      .led(led), .seg_an(seg_an), .seg_data(seg_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // n counts non-reset edges since reset, which fixes the expected scan digit
   task automatic step();
      @(posedge clock);
      if (reset) n = 0;
      else n++;
      #1;
   endtask

   task automatic idle();
      IORead = 1'b0; IOWrite = 1'b0; addr_low = '0; wdata = '0;
   endtask

   task automatic read_btn(input string name, input logic [31:0] exp);
      IORead = 1'b1; addr_low = 10'h074; #1;
      chk(name, rdata, exp);
   endtask

   initial begin
      logic [7:0]  e_an, e_sd;
      logic [2:0]  idx;
      logic [31:0] shifted;

      vecs[0] = '{1'b0, 1'b1, 10'h060, 32'h12ABCDEF, 32'h0, 24'hABCDEF};
      vecs[1] = '{1'b0, 1'b1, 10'h06C, 32'hFFFFFFFF, 32'h0, 24'hABCDEF};
      vecs[2] = '{1'b1, 1'b0, 10'h060, 32'h0,        32'h0, 24'hABCDEF};
      vecs[3] = '{1'b1, 1'b0, 10'h070, 32'h0,        32'h0, 24'hABCDEF};
      vecs[4] = '{1'b0, 1'b1, 10'h063, 32'h00000123, 32'h0, 24'h000123};
      vecs[5] = '{1'b1, 1'b1, 10'h060, 32'h00ABCDEF, 32'h0, 24'hABCDEF};
      vecs[6] = '{1'b0, 1'b1, 10'h3FC, 32'h0,        32'h0, 24'hABCDEF};
      vecs[7] = '{1'b1, 1'b0, 10'h074, 32'h0,        32'h0, 24'hABCDEF};

      disps[0] = '{32'h00000010, 8'h03};
      disps[1] = '{32'h76543210, 8'hFF};
      disps[2] = '{32'hFEDCBA98, 8'hA5};

      idle();
      switch_in = '0; button_in = 1'b0; reset = 1'b1;
      step(); step();
      reset = 1'b0;
      chk("rst_led", {8'h0, led}, 32'h0);
      chk("rst_seg_an", {24'h0, seg_an}, 32'hFF);
      chk("rst_seg_data", {24'h0, seg_data}, 32'hFF);
      IORead = 1'b1; addr_low = 10'h070; #1;
      chk("rst_rdata", rdata, 32'h0);
      idle();

      for (int i = 0; i < 8; i++) begin
         IORead = vecs[i].rd; IOWrite = vecs[i].wr;
         addr_low = vecs[i].addr; wdata = vecs[i].wd; #1;
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         step();
         idle();
         chk($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
      end

      // Reset with LED = ABCDEF and a simultaneous write
      reset = 1'b1; IOWrite = 1'b1; addr_low = 10'h060; wdata = 32'h00111111;
      step();
      reset = 1'b0; idle();
      chk("rst2_led", {8'h0, led}, 32'h0);
      chk("rst2_seg_an", {24'h0, seg_an}, 32'hFF);
      chk("rst2_seg_data", {24'h0, seg_data}, 32'hFF);
      IORead = 1'b1; addr_low = 10'h070; #1;
      chk("rst2_rdata", rdata, 32'h0);
      idle();

      for (int p = 0; p < 3; p++) begin
         IOWrite = 1'b1; addr_low = 10'h064; wdata = disps[p].segd;
         step();
         addr_low = 10'h068; wdata = {24'h0, disps[p].en};
         step();
         idle();
         for (int c = 0; c < 40; c++) begin
            idx = 3'((n / 4) % 8);
            e_an = 8'hFF;
            if (disps[p].en[idx]) e_an[idx] = 1'b0;
            shifted = disps[p].segd >> (4 * idx);
            e_sd = disps[p].en[idx] ? dec[shifted[3:0]] : 8'hFF;
            chk($sformatf("disp%0d_an_d%0d", p, idx), {24'h0, seg_an}, {24'h0, e_an});
            chk($sformatf("disp%0d_sd_d%0d", p, idx), {24'h0, seg_data}, {24'h0, e_sd});
            step();
         end
      end

      switch_in = 24'h5A5A5A; IORead = 1'b1; addr_low = 10'h070; #1;
      chk("sw_edge0", rdata, 32'h0);
      step();
      chk("sw_edge1", rdata, 32'h0);
      step();
      chk("sw_edge2", rdata, 32'h005A5A5A);
      IORead = 1'b0; #1;
      chk("sw_noread", rdata, 32'h0);
      switch_in = '0;
      step(); step();

      // Bounce shorter than the debounce window
      button_in = 1'b1;
      repeat (5) step();
      button_in = 1'b0;
      repeat (15) step();
      read_btn("btn_bounce", 32'h0);
      idle();

      button_in = 1'b1;
      repeat (9) step();
      read_btn("btn_edge9", 32'h0);
      idle(); #1;
      step();
      read_btn("btn_edge10", 32'h3);
      step();
      chk("btn_cleared", rdata, 32'h1);
      idle();

      button_in = 1'b0;
      repeat (12) step();
      read_btn("btn_released", 32'h0);
      idle(); #1;

      // Read-clear coincides with the rising edge of btn_stable
      button_in = 1'b1;
      repeat (9) step();
      read_btn("btn_same_pre", 32'h0);
      step();
      chk("btn_same_edge", rdata, 32'h3);
      step();
      chk("btn_same_after", rdata, 32'h1);
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
